// File: rtl/dht11_pkg.sv
// Shared types and constants for the DHT11 read scheduler: FSM encoding, 40-bit frame
// field offsets and small constant helpers used to size counters.
package dht11_pkg;

  typedef enum logic [2:0] {
    S_PWRUP,
    S_START,
    S_WAIT,
    S_CHECK,
    S_UPDATE,
    S_FAILED,
    S_RWAIT,
    S_IDLE
  } state_e;

  // LSB of each byte in the {hum_int,hum_dec,tmp_int,tmp_dec,chksum} frame
  localparam int HUM_INT_LSB = 32;
  localparam int HUM_DEC_LSB = 24;
  localparam int TMP_INT_LSB = 16;
  localparam int TMP_DEC_LSB = 8;
  localparam int CHK_LSB     = 0;

  function automatic int cycles_per_ms(input int clk_hz);
    return (clk_hz >= 2000) ? clk_hz / 1000 : 1;
  endfunction

  // Bits needed to hold the values 0..n (never less than 1)
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/dht11_read_scheduler_ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every CLK_HZ/1000 clocks.
module ms_tick_gen
  import dht11_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int DIV = cycles_per_ms(CLK_HZ);
  localparam int W   = cnt_w(DIV - 1);

  logic [W-1:0] cnt;

  assign tick = rst_n && (cnt == W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || tick) cnt <= '0;
    else                cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/dht11_read_scheduler.sv
// DHT11 read sequencer: power-up delay, periodic requests, timeout, checksum check,
// bounded retries, and hold of the last good sample for the display path.
module dht11_read_scheduler
  import dht11_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int POWERUP_MS = 1000,
  parameter int PERIOD_MS  = 2000,
  parameter int RETRY_MS   = 1000,
  parameter int TIMEOUT_MS = 30,
  parameter int MAX_RETRY  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        rd_start,
  input  logic        rd_done,
  input  logic [39:0] rd_data,
  output logic [7:0]  hum_int,
  output logic [7:0]  tmp_int,
  output logic [7:0]  tmp_dec,
  output logic        valid,
  output logic        fail,
  output logic [7:0]  err_cnt,
  output logic [15:0] sample_cnt
);

  localparam int DMAX = (POWERUP_MS > RETRY_MS)
                        ? ((POWERUP_MS > TIMEOUT_MS) ? POWERUP_MS : TIMEOUT_MS)
                        : ((RETRY_MS > TIMEOUT_MS) ? RETRY_MS : TIMEOUT_MS);
  localparam int DW = cnt_w(DMAX);
  localparam int PW = cnt_w(PERIOD_MS);
  localparam int RW = cnt_w(MAX_RETRY);

  state_e        state, nxt;
  logic          tick;
  logic [DW-1:0] dly_cnt, dly_lim;
  logic [PW-1:0] per_cnt;
  logic [RW-1:0] retry;
  logic [39:0]   data_q;
  logic [7:0]    sum;
  logic          dly_hit, per_hit, chk_ok;

  ms_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  // One shared delay counter; which limit applies depends on the state it times
  assign dly_lim = (state == S_PWRUP) ? DW'(POWERUP_MS)
                 : (state == S_WAIT)  ? DW'(TIMEOUT_MS)
                 :                      DW'(RETRY_MS);
  assign dly_hit = tick && (dly_cnt == dly_lim - 1'b1);
  assign per_hit = (per_cnt == PW'(PERIOD_MS)) ||
                   (tick && (per_cnt == PW'(PERIOD_MS - 1)));

  assign sum    = data_q[HUM_INT_LSB +: 8] + data_q[HUM_DEC_LSB +: 8] +
                  data_q[TMP_INT_LSB +: 8] + data_q[TMP_DEC_LSB +: 8];
  assign chk_ok = (sum == data_q[CHK_LSB +: 8]);

  always_comb begin
    nxt      = state;
    rd_start = 1'b0;
    unique case (state)
      S_PWRUP:  if (dly_hit) nxt = S_START;
      S_START: begin
        rd_start = 1'b1;
        nxt      = S_WAIT;
      end
      S_WAIT: begin
        if (rd_done)      nxt = S_CHECK;
        else if (dly_hit) nxt = S_FAILED;
      end
      S_CHECK:  nxt = chk_ok ? S_UPDATE : S_FAILED;
      S_UPDATE: nxt = S_IDLE;
      S_FAILED: nxt = (retry < RW'(MAX_RETRY)) ? S_RWAIT : S_IDLE;
      S_RWAIT:  if (dly_hit) nxt = S_START;
      S_IDLE:   if (per_hit) nxt = S_START;
      default:  nxt = S_PWRUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_PWRUP;
      dly_cnt    <= '0;
      per_cnt    <= '0;
      retry      <= '0;
      data_q     <= '0;
      hum_int    <= '0;
      tmp_int    <= '0;
      tmp_dec    <= '0;
      valid      <= 1'b0;
      fail       <= 1'b0;
      err_cnt    <= '0;
      sample_cnt <= '0;
    end else begin
      state <= nxt;

      if (nxt != state) dly_cnt <= '0;
      else if (tick)    dly_cnt <= dly_cnt + 1'b1;

      // The START cycle's own tick counts toward the start-to-start period
      if (state == S_START)                         per_cnt <= tick ? PW'(1) : '0;
      else if (tick && per_cnt != PW'(PERIOD_MS))   per_cnt <= per_cnt + 1'b1;

      if (state == S_WAIT && rd_done) data_q <= rd_data;

      if (state == S_UPDATE) begin
        hum_int    <= data_q[HUM_INT_LSB +: 8];
        tmp_int    <= data_q[TMP_INT_LSB +: 8];
        tmp_dec    <= data_q[TMP_DEC_LSB +: 8];
        valid      <= 1'b1;
        fail       <= 1'b0;
        retry      <= '0;
        sample_cnt <= sample_cnt + 1'b1;
      end

      if (state == S_FAILED) begin
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
        if (retry < RW'(MAX_RETRY)) begin
          retry <= retry + 1'b1;
        end else begin
          fail  <= 1'b1;
          retry <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dht11_read_scheduler.sv
// Directed-plus-random bench for dht11_read_scheduler with an event-level reference model.
module tb_dht11_read_scheduler;

  localparam int CLK_HZ    = 1000;
  localparam int POWERUP   = 10;
  localparam int PERIOD    = 50;
  localparam int RETRY     = 20;
  localparam int TIMEOUT   = 5;
  localparam int MAX_RETRY = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_start;
  logic        rd_done = 1'b0;
  logic [39:0] rd_data = '0;
  logic [7:0]  hum_int, tmp_int, tmp_dec, err_cnt;
  logic        valid, fail;
  logic [15:0] sample_cnt;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [7:0] m_hum, m_tmp, m_tdec;
  logic       m_valid, m_fail;
  int         m_err, m_samp, m_retry;
  int         exp_start, c0;

  dht11_read_scheduler #(
    .CLK_HZ(CLK_HZ), .POWERUP_MS(POWERUP), .PERIOD_MS(PERIOD),
    .RETRY_MS(RETRY), .TIMEOUT_MS(TIMEOUT), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rd_start(rd_start), .rd_done(rd_done),
    .rd_data(rd_data), .hum_int(hum_int), .tmp_int(tmp_int), .tmp_dec(tmp_dec),
    .valid(valid), .fail(fail), .err_cnt(err_cnt), .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;
  // cyc = number of rising edges so far; read at the falling edge
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: run did not finish, got time %0t want < 3000000", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, ".hum_int"},    hum_int,    m_hum);
    chk({tag, ".tmp_int"},    tmp_int,    m_tmp);
    chk({tag, ".tmp_dec"},    tmp_dec,    m_tdec);
    chk({tag, ".valid"},      valid,      m_valid);
    chk({tag, ".fail"},       fail,       m_fail);
    chk({tag, ".err_cnt"},    err_cnt,    m_err[7:0]);
    chk({tag, ".sample_cnt"}, sample_cnt, m_samp[15:0]);
  endtask

  task automatic model_reset();
    m_hum = 0; m_tmp = 0; m_tdec = 0; m_valid = 0; m_fail = 0;
    m_err = 0; m_samp = 0; m_retry = 0;
  endtask

  function automatic bit sum_ok(input logic [39:0] d);
    int s;
    s = int'(d[39:32]) + int'(d[31:24]) + int'(d[23:16]) + int'(d[15:8]);
    return (s % 256) == int'(d[7:0]);
  endfunction

  function automatic logic [39:0] mk(input bit good);
    logic [31:0] p;
    logic [7:0]  c;
    int          s;
    p = $urandom;
    s = int'(p[31:24]) + int'(p[23:16]) + int'(p[15:8]) + int'(p[7:0]);
    c = 8'(s % 256);
    if (!good) c = 8'((s + 1 + int'($urandom_range(0, 254))) % 256);
    return {p, c};
  endfunction

  task automatic model_good(input logic [39:0] d);
    m_hum = d[39:32]; m_tmp = d[23:16]; m_tdec = d[15:8];
    m_valid = 1; m_fail = 0; m_retry = 0;
    m_samp = (m_samp + 1) % 65536;
    exp_start = c0 + PERIOD;
  endtask

  // f = cycle in which the attempt is judged failed
  task automatic model_fail(input int f);
    m_err = (m_err < 255) ? m_err + 1 : 255;
    if (m_retry < MAX_RETRY) begin
      m_retry++;
      exp_start = f + 1 + RETRY;
    end else begin
      m_fail = 1;
      m_retry = 0;
      exp_start = (c0 + PERIOD > f + 2) ? c0 + PERIOD : f + 2;
    end
  endtask

  task automatic wait_start();
    while (rd_start !== 1'b1 && cyc < exp_start + 3) @(negedge clk);
    chk("start_cycle", cyc, exp_start);
    c0 = cyc;
    @(negedge clk);
    chk("start_one_cycle", rd_start, 1'b0);
  endtask

  // k = cycles after the rd_start cycle at which rd_done is pulsed; k=0 means no reply
  task automatic attempt(input int k, input logic [39:0] d);
    int w;
    wait_start();
    if (k == 0) begin
      while (cyc < c0 + TIMEOUT + 2) @(negedge clk);
      model_fail(c0 + TIMEOUT + 1);
      chk_outs("timeout");
    end else begin
      repeat (k - 1) @(negedge clk);
      rd_done = 1'b1; rd_data = d; w = cyc;
      @(negedge clk);
      rd_done = 1'b0; rd_data = {$urandom, 8'($urandom)};
      @(negedge clk);
      // rd_done sampled at the next edge, then CHECK and UPDATE: nothing visible yet
      chk("latency_samp", sample_cnt, m_samp[15:0]);
      chk("latency_err", err_cnt, m_err[7:0]);
      @(negedge clk);
      if (sum_ok(d)) begin
        model_good(d);
        chk_outs("good");
      end else begin
        model_fail(w + 2);
        chk_outs("bad_chk");
      end
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk_outs("reset");
    chk("reset.rd_start", rd_start, 1'b0);
    rst_n = 1'b1;
    exp_start = cyc + POWERUP;

    // first read with the reference frame
    attempt(int'($urandom_range(1, TIMEOUT)), 40'h37_00_1A_05_56);

    // bad checksum every attempt: retries exhaust, then a good read clears fail
    for (int i = 0; i < MAX_RETRY + 1; i++)
      attempt(int'($urandom_range(1, TIMEOUT)), 40'h37_00_1A_05_57);
    attempt(int'($urandom_range(1, TIMEOUT)), mk(1'b1));

    // timeout, then a reply on the exact expiry cycle
    attempt(0, '0);
    attempt(TIMEOUT, mk(1'b1));

    // spurious rd_done while idle
    repeat (2) @(negedge clk);
    rd_done = 1'b1; rd_data = mk(1'b1);
    @(negedge clk);
    rd_done = 1'b0;
    repeat (3) @(negedge clk);
    chk_outs("spurious");

    // reset in the middle of a transfer
    wait_start();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    chk_outs("reset_mid_wait");
    chk("reset_mid_wait.rd_start", rd_start, 1'b0);
    rst_n = 1'b1;
    exp_start = cyc + POWERUP;

    // random mix of outcomes
    for (int i = 0; i < 20; i++) begin
      int mode;
      mode = int'($urandom_range(0, 2));
      if (mode == 0) attempt(0, '0);
      else attempt(int'($urandom_range(1, TIMEOUT)), mk(mode == 2));
    end

    // drive err_cnt into saturation
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) attempt(0, '0);
      else attempt(int'($urandom_range(1, TIMEOUT)), mk(1'b0));
    end
    chk("err_saturated", err_cnt, 8'd255);

    // sample counter wrap from a preloaded 65535
    force dut.sample_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.sample_cnt;
    m_samp = 65535;
    chk("preload", sample_cnt, 16'hFFFF);
    attempt(int'($urandom_range(1, TIMEOUT)), mk(1'b1));
    chk("sample_wrap", sample_cnt, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
